// File: rtl/key_event.sv
// key_event: per-key synchroniser, debouncer and press/release/long/repeat event generator.
// Each key bit is an independent lane; every output is driven straight from a flop.
module key_event #(
    parameter int N             = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key,
    output logic [N-1:0] key_pulse,
    output logic [N-1:0] key_release,
    output logic [N-1:0] key_long,
    output logic [N-1:0] key_repeat,
    output logic [N-1:0] key_state
);

    localparam int DW       = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_HELD,
        ST_LONG
    } state_t;

    // Internally a 1 always means "pressed".
    logic [N-1:0] w_norm;
    assign w_norm = (ACTIVE_LOW != 0) ? ~key : key;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_lane
            logic [1:0]    r_sync;
            logic          r_deb;
            logic [DW-1:0] r_deb_cnt;
            state_t        r_st;
            state_t        w_st_nxt;
            logic [HW-1:0] r_hold;
            logic [HW-1:0] w_hold_nxt;
            logic          w_press;
            logic          w_rel;
            logic          w_long;
            logic          w_rep;
            logic          r_pulse;
            logic          r_rel;
            logic          r_long;
            logic          r_rep;
            logic          r_level;

            // Debounce: any cycle of agreement restarts the stability count.
            always_ff @(posedge clk) begin : p_sync_deb
                if (!rst) begin
                    r_sync    <= '0;
                    r_deb     <= 1'b0;
                    r_deb_cnt <= '0;
                end else begin
                    r_sync <= {r_sync[0], w_norm[g]};
                    if (r_sync[1] == r_deb) begin
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_deb     <= r_sync[1];
                        r_deb_cnt <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin : p_state
                if (!rst) begin
                    r_st    <= ST_RELEASED;
                    r_hold  <= '0;
                    r_pulse <= 1'b0;
                    r_rel   <= 1'b0;
                    r_long  <= 1'b0;
                    r_rep   <= 1'b0;
                    r_level <= 1'b0;
                end else begin
                    r_st    <= w_st_nxt;
                    r_hold  <= w_hold_nxt;
                    r_pulse <= w_press;
                    r_rel   <= w_rel;
                    r_long  <= w_long;
                    r_rep   <= w_rep;
                    r_level <= r_deb;
                end
            end

            // Hold counter clears on every transition and terminal count, so it never wraps.
            always_comb begin : p_next
                w_st_nxt   = r_st;
                w_hold_nxt = '0;
                case (r_st)
                    ST_RELEASED: begin
                        if (r_deb) begin
                            w_st_nxt = ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (!r_deb) begin
                            w_st_nxt = ST_RELEASED;
                        end else if (r_hold == LONG_LAST) begin
                            w_st_nxt = ST_LONG;
                        end else begin
                            w_hold_nxt = r_hold + 1'b1;
                        end
                    end
                    ST_LONG: begin
                        if (!r_deb) begin
                            w_st_nxt = ST_RELEASED;
                        end else if (r_hold != REP_LAST) begin
                            w_hold_nxt = r_hold + 1'b1;
                        end
                    end
                    default: begin
                        w_st_nxt = ST_RELEASED;
                    end
                endcase
            end

            // Release wins over a long/repeat falling due on the same cycle.
            always_comb begin : p_out
                w_press = 1'b0;
                w_rel   = 1'b0;
                w_long  = 1'b0;
                w_rep   = 1'b0;
                case (r_st)
                    ST_RELEASED: begin
                        w_press = r_deb;
                    end
                    ST_HELD: begin
                        w_rel  = !r_deb;
                        w_long = r_deb && (r_hold == LONG_LAST);
                    end
                    ST_LONG: begin
                        w_rel = !r_deb;
                        w_rep = r_deb && (r_hold == REP_LAST);
                    end
                    default: begin
                        w_rel = 1'b0;
                    end
                endcase
            end

            assign key_pulse[g]   = r_pulse;
            assign key_release[g] = r_rel;
            assign key_long[g]    = r_long;
            assign key_repeat[g]  = r_rep;
            assign key_state[g]   = r_level;
        end
    endgenerate

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: directed scenarios plus random key activity, checked every cycle
// against a history-window / elapsed-time reference model.
module tb_key_event;

    localparam int N     = 4;
    localparam int DEB   = 4;
    localparam int LONGC = 10;
    localparam int REP   = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] key = '0;
    logic [N-1:0] key_pulse;
    logic [N-1:0] key_release;
    logic [N-1:0] key_long;
    logic [N-1:0] key_repeat;
    logic [N-1:0] key_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    key_event #(
        .N(N),
        .ACTIVE_LOW(1),
        .DEB_CYCLES(DEB),
        .LONG_CYCLES(LONGC),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key(key),
        .key_pulse(key_pulse),
        .key_release(key_release),
        .key_long(key_long),
        .key_repeat(key_repeat),
        .key_state(key_state)
    );

    always #5 clk = ~clk;

    // Reference model: hv holds the pressed-level samples seen at past edges (bit0 newest),
    // lvl is the accepted level, held/tp track the press and when its pulse fired.
    logic [15:0]  hv [N];
    logic [N-1:0] lvl = '0;
    logic [N-1:0] held = '0;
    int           tp [N];
    logic [N-1:0] e_pulse = '0, e_rel = '0, e_long = '0, e_rep = '0, e_state = '0;
    logic         m_acc;
    int           m_d;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            for (int l = 0; l < N; l++) begin
                hv[l] = '0;
                tp[l] = 0;
            end
            lvl = '0; held = '0;
            e_pulse = '0; e_rel = '0; e_long = '0; e_rep = '0; e_state = '0;
        end else begin
            for (int l = 0; l < N; l++) begin
                e_pulse[l] = 1'b0; e_rel[l] = 1'b0; e_long[l] = 1'b0; e_rep[l] = 1'b0;
                if (!held[l] && lvl[l]) begin
                    e_pulse[l] = 1'b1; held[l] = 1'b1; tp[l] = cyc;
                end else if (held[l] && !lvl[l]) begin
                    e_rel[l] = 1'b1; held[l] = 1'b0;
                end else if (held[l]) begin
                    m_d = cyc - tp[l];
                    if (m_d == LONGC) e_long[l] = 1'b1;
                    else if (m_d > LONGC && ((m_d - LONGC) % REP) == 0) e_rep[l] = 1'b1;
                end
                e_state[l] = lvl[l];
                // Samples from 2..DEB+1 edges ago must all disagree with the accepted level.
                m_acc = 1'b1;
                for (int k = 1; k <= DEB; k++)
                    if (hv[l][k] == lvl[l]) m_acc = 1'b0;
                if (m_acc) lvl[l] = ~lvl[l];
                hv[l] = {hv[l][14:0], ~key[l]};
            end
        end
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("pulse",   key_pulse,   e_pulse);
        chk("release", key_release, e_rel);
        chk("long",    key_long,    e_long);
        chk("repeat",  key_repeat,  e_rep);
        chk("state",   key_state,   e_state);
    endtask

    int dur [N];

    initial begin
        // Reset with all keys pressed; re-accepted as presses once reset lifts.
        rst = 1'b0; key = '0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("rst_out", key_pulse | key_release | key_long | key_repeat | key_state, 4'b0000);
        end
        for (int j = 1; j <= 20; j++) begin
            rst = 1'b1;
            key = (j <= 8) ? 4'b0000 : 4'b1111;
            step();
            chk("rst_press", key_pulse, (j == 7) ? 4'b1111 : 4'b0000);
            chk("rst_rel", key_release, (j == 15) ? 4'b1111 : 4'b0000);
        end

        // Glitch on key 0 shorter than the debounce window.
        for (int j = 1; j <= 14; j++) begin
            key[0] = (j <= 3) ? 1'b0 : 1'b1;
            step();
            chk("glitch_state", key_state, 4'b0000);
            chk("glitch_evt", key_pulse | key_release, 4'b0000);
        end

        // Clean press/release on key 1.
        for (int j = 1; j <= 20; j++) begin
            key[1] = (j <= 8) ? 1'b0 : 1'b1;
            step();
            chk("clean_pulse", key_pulse, (j == 7) ? 4'b0010 : 4'b0000);
            chk("clean_rel", key_release, (j == 15) ? 4'b0010 : 4'b0000);
            chk("clean_state", key_state, (j >= 7 && j <= 14) ? 4'b0010 : 4'b0000);
        end

        // Long press plus auto-repeat on key 2, held for 30 cycles.
        for (int j = 1; j <= 45; j++) begin
            key[2] = (j <= 30) ? 1'b0 : 1'b1;
            step();
            chk("lr_pulse", key_pulse, (j == 7) ? 4'b0100 : 4'b0000);
            chk("lr_long", key_long, (j == 17) ? 4'b0100 : 4'b0000);
            chk("lr_repeat", key_repeat,
                (j >= 20 && j <= 35 && ((j - 20) % 3) == 0) ? 4'b0100 : 4'b0000);
            chk("lr_rel", key_release, (j == 37) ? 4'b0100 : 4'b0000);
        end

        // Release accepted on exactly the cycle the first repeat is due.
        for (int j = 1; j <= 30; j++) begin
            key[2] = (j <= 13) ? 1'b0 : 1'b1;
            step();
            chk("col_long", key_long, (j == 17) ? 4'b0100 : 4'b0000);
            chk("col_rel", key_release, (j == 20) ? 4'b0100 : 4'b0000);
            chk("col_repeat", key_repeat, 4'b0000);
            chk("col_state", key_state, (j >= 7 && j <= 19) ? 4'b0100 : 4'b0000);
        end

        // Simultaneous presses on keys 0 and 3, then reset while key 3 is in long-press.
        for (int j = 1; j <= 45; j++) begin
            key[0] = (j <= 8) ? 1'b0 : 1'b1;
            key[3] = (j <= 30) ? 1'b0 : 1'b1;
            rst    = (j == 19 || j == 20) ? 1'b0 : 1'b1;
            step();
            if (j == 7) chk("ind_pulse", key_pulse, 4'b1001);
            if (j == 17) chk("ind_long", key_long, 4'b1000);
            if (j >= 19 && j <= 26) chk("midrst_state", key_state, 4'b0000);
            if (j >= 19) chk("midrst_rel", key_release & 4'b1000, (j == 37) ? 4'b1000 : 4'b0000);
            if (j >= 19) chk("midrst_pulse", key_pulse, (j == 27) ? 4'b1000 : 4'b0000);
            if (j >= 19) chk("midrst_long", key_long, 4'b0000);
        end

        // Random key activity with occasional resets.
        for (int l = 0; l < N; l++) dur[l] = 0;
        for (int j = 0; j < 900; j++) begin
            for (int l = 0; l < N; l++) begin
                if (dur[l] == 0) begin
                    key[l] = 1'($urandom_range(0, 1));
                    dur[l] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                         : int'($urandom_range(5, 40));
                end
                dur[l]--;
            end
            rst = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
